// File: rtl/systolic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : systolic_mul_arbiter
// Brief  : Round-robin sharing of one fixed-latency 4x4 multiplier among NREQ
//          requesters, with a tagged valid/ready response channel.
// Rev    : 1.0
// ============================================================================
module systolic_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_p,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_p,
  output logic              busy
);

  localparam int             c_CNT_W   = $clog2(MUL_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_LAT - 1);
  localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           a_q, a_d, b_q, b_d;
  logic                 rv_q, rv_d;
  logic [7:0]           p_q, p_d;

  logic [NREQ-1:0]      w_rot, w_lo, w_oh;
  logic [IDW-1:0]       w_gnt_idx;
  logic [3:0]           w_sel_a, w_sel_b;
  logic [IDW-1:0][NREQ-1:0] w_idx_col;
  logic [3:0][NREQ-1:0]     w_a_col, w_b_col;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_rot = NREQ'({req_valid, req_valid} >> ptr_q);
  assign w_lo  = w_rot & (~w_rot + NREQ'(1));
  assign w_oh  = NREQ'(({w_lo, w_lo} << ptr_q) >> NREQ);

  for (genvar j = 0; j < NREQ; j++) begin : g_col
    for (genvar b = 0; b < IDW; b++) begin : g_idx
      assign w_idx_col[b][j] = w_oh[j] & 1'((j >> b) & 1);
    end
    for (genvar m = 0; m < 4; m++) begin : g_opd
      assign w_a_col[m][j] = w_oh[j] & req_a[4*j+m];
      assign w_b_col[m][j] = w_oh[j] & req_b[4*j+m];
    end
  end

  for (genvar b = 0; b < IDW; b++) begin : g_idx_or
    assign w_gnt_idx[b] = |w_idx_col[b];
  end

  for (genvar m = 0; m < 4; m++) begin : g_opd_or
    assign w_sel_a[m] = |w_a_col[m];
    assign w_sel_b[m] = |w_b_col[m];
  end

  assign req_ready = (state_q == S_IDLE && !rst) ? w_oh : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rv_d    = rv_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (|w_oh) begin
          a_d     = w_sel_a;
          b_d     = w_sel_b;
          id_d    = w_gnt_idx;
          ptr_d   = (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + IDW'(1);
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + c_CNT_W'(1);
        if (cnt_q == c_CNT_LAST) begin
          p_d     = mul_p;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rv_q    <= rv_d;
      p_q     <= p_d;
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = rv_q;
  assign rsp_p     = p_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_mul_arbiter
// Brief  : Self-checking bench: directed tables plus randomized ops vs a model.
// Rev    : 1.0
// ============================================================================
module tb_systolic_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic [3:0]        mul_a, mul_b;
  logic [7:0]        mul_p;
  logic              busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined multiplier: product is only correct after MUL_LAT-1 stable edges.
  logic [7:0] pipe_q [MUL_LAT-1];
  always @(posedge clk) begin
    pipe_q[0] <= 8'(mul_a) * 8'(mul_b);
    for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign mul_p = pipe_q[MUL_LAT-2];

  systolic_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (((int'(v) >> ((p + i) % NREQ)) & 1) == 1) return (p + i) % NREQ;
    return -1;
  endfunction

  // Waits for a grant, follows the op to its response; returns at the negedge
  // where rsp_valid is first seen. Caller owns rsp_ready.
  task automatic serve(input string tag, input bit scramble,
                       output int gid, output int gp, output int acc);
    int t;
    int exp_g;
    logic [3:0] ea, eb;
    bit held;
    gid = -1; gp = -1; acc = -1; t = 0;
    #1;
    while (req_ready == '0 && t < 40) begin
      @(negedge clk); #1; t++;
    end
    if (req_ready == '0) begin
      check({tag, " grant timeout"}, 0, 1);
      return;
    end
    exp_g = pick(req_valid, ptr_m);
    check({tag, " one-hot"}, $countones(req_ready), 1);
    gid = $clog2(int'(req_ready));
    check({tag, " grant"}, gid, exp_g);
    ea = 4'(req_a >> (4 * exp_g));
    eb = 4'(req_b >> (4 * exp_g));
    ptr_m = (exp_g + 1) % NREQ;
    acc = cyc;
    @(negedge clk);
    if (scramble) begin
      req_a = req_a ^ (16'hF << (4 * exp_g));
      req_b = req_b ^ (16'h5 << (4 * exp_g));
    end
    check({tag, " busy"}, int'(busy), 1);
    held = 1'b1; t = 0;
    while (!rsp_valid && t < 40) begin
      if (mul_a !== ea || mul_b !== eb || req_ready !== '0) held = 1'b0;
      @(negedge clk); t++;
    end
    check({tag, " latency"}, t, MUL_LAT);
    check({tag, " operands held"}, int'(held), 1);
    check({tag, " rsp_id"}, int'(rsp_id), exp_g);
    check({tag, " rsp_p"}, int'(rsp_p), int'(ea) * int'(eb));
    gp = int'(rsp_p);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         id;
    int         p;
  } vec_t;

  vec_t rr [4];
  int   fair_exp [4];
  int   g, p, acc, prev_acc, t;
  bit   ok;

  initial begin
    rr[0] = '{4'd1,  4'd2,  0, 2};
    rr[1] = '{4'd3,  4'd4,  1, 12};
    rr[2] = '{4'd5,  4'd6,  2, 30};
    rr[3] = '{4'd15, 4'd15, 3, 225};
    fair_exp = '{3, 2, 3, 2};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset state, with a request already pending.
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst req_ready", int'(req_ready), 0);
    check("rst rsp_valid", int'(rsp_valid), 0);
    check("rst rsp_p", int'(rsp_p), 0);
    check("rst rsp_id", int'(rsp_id), 0);
    check("rst mul_a/b", int'({mul_a, mul_b}), 0);
    check("rst busy", int'(busy), 0);

    // Single op.
    @(negedge clk); rst = 1'b0; ptr_m = 0;
    serve("single", 1'b0, g, p, acc);
    check("single product", p, 15);
    check("single busy in RESP", int'(busy), 1);
    req_valid = '0;
    @(negedge clk); #1;
    check("single busy after hs", int'(busy), 0);
    check("single rsp_valid after hs", int'(rsp_valid), 0);

    // Round-robin from ptr=0, all four requesting.
    @(negedge clk); rst = 1'b1; ptr_m = 0;
    @(negedge clk); rst = 1'b0;
    req_a = '0; req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a = req_a | (16'(rr[i].a) << (4 * i));
      req_b = req_b | (16'(rr[i].b) << (4 * i));
    end
    req_valid = 4'b1111;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      serve("rr", 1'b0, g, p, acc);
      check("rr order", g, rr[i].id);
      check("rr product", p, rr[i].p);
      if (i > 0) check("rr spacing", acc - prev_acc, MUL_LAT + 2);
      prev_acc = acc;
      if (g >= 0) req_valid = req_valid & ~(4'b0001 << g);
    end

    // Fairness: ptr moved to 3, then requesters 2 and 3 held valid.
    req_valid = 4'b0100;
    serve("fair prime", 1'b0, g, p, acc);
    req_valid = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      serve("fair", 1'b0, g, p, acc);
      check("fair order", g, fair_exp[i]);
    end

    // Backpressure during RESP with another requester waiting.
    req_valid = 4'b0001; req_a = 16'h0002; req_b = 16'h0009;
    @(negedge clk);
    serve("bp", 1'b0, g, p, acc);
    rsp_ready = 1'b0;
    req_valid = 4'b0010; req_a = 16'h0060; req_b = 16'h0070;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_p !== 8'd18 || rsp_id !== 2'd0 ||
          mul_a !== 4'd2 || mul_b !== 4'd9 || req_ready !== '0) ok = 1'b0;
    end
    check("bp stable 20 cycles", int'(ok), 1);
    rsp_ready = 1'b1; #1;
    check("bp ready before hs", int'(req_ready), 0);
    @(negedge clk); #1;
    check("bp ready after hs", int'(req_ready), 2);
    serve("bp next", 1'b0, g, p, acc);
    check("bp next product", p, 42);

    // Mid-op reset at cnt=4.
    req_valid = 4'b0001; req_a = 16'h0007; req_b = 16'h0009;
    t = 0;
    @(negedge clk); #1;
    while (req_ready == '0 && t < 40) begin
      @(negedge clk); #1; t++;
    end
    check("rst-mid grant", int'(req_ready), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1; ptr_m = 0; #1;
    check("rst-mid outputs", int'({rsp_valid, busy, mul_a, mul_b, rsp_p}), 0);
    check("rst-mid req_ready", int'(req_ready), 0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("rst-mid quiet", int'(ok), 1);
    rst = 1'b0;
    serve("rst-mid again", 1'b0, g, p, acc);
    check("rst-mid product", p, 63);

    // Operand hold: requester changes its operands right after accept.
    req_valid = 4'b0001; req_a = 16'h0004; req_b = 16'h000B;
    @(negedge clk);
    serve("hold", 1'b1, g, p, acc);
    check("hold product", p, 44);

    // Randomized traffic with random backpressure.
    for (int it = 0; it < 40; it++) begin
      req_valid = 4'($urandom_range(1, 15));
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      serve("rand", 1'($urandom_range(0, 1)), g, p, acc);
      rsp_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rsp_ready = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/systolic_mul_arbiter.md
Name: systolic_mul_arbiter

Overview:
- Shares one 4x4 systolic multiplier instance among NREQ requesters. Each requester presents a pair of 4-bit operands.
- Round-robin arbitration selects one request at a time. The controller registers the operands and holds them on the multiplier inputs for MUL_LAT cycles.
- It then captures the 8-bit product and returns it, tagged with the requester index, over a valid/ready response channel.
- Sits between client logic and the multiplier; the multiplier itself is not modified.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2^IDW >= NREQ.
- MUL_LAT, 8, cycles operands are held before mul_p is sampled (>= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  4*NREQ  multiplicands; requester k uses bits [4k+3:4k].
- req_b  in  4*NREQ  multipliers; requester k uses bits [4k+3:4k].
- req_ready  out  NREQ  one-hot (or zero) accept; combinational from state and req_valid.
- rsp_valid  out  1  response valid.
- rsp_p  out  8  product a*b.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_ready  in  1  response consumer ready.
- mul_a  out  4  operand to multiplier a.
- mul_b  out  4  operand to multiplier b.
- mul_p  in  8  multiplier product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, cnt=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0. req_ready=0 while rst is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - g = first k in ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ) with req_valid[k]=1.
  - req_ready[g]=1; all other req_ready bits 0. If no request is valid, req_ready=0 and state stays IDLE.
  - On the accept edge: mul_a<=req_a[g], mul_b<=req_b[g], rsp_id<=g, ptr<=(g+1) mod NREQ, cnt<=0, state<=WAIT.
- WAIT:
  - req_ready=0; mul_a and mul_b held constant.
  - Each edge: cnt<=cnt+1.
  - On the edge where cnt==MUL_LAT-1: rsp_p<=mul_p, rsp_valid<=1, state<=RESP.
  - Net timing: rsp_valid is first high exactly MUL_LAT cycles after the accept edge. The multiplier sees stable operands for MUL_LAT full cycles.
- RESP:
  - rsp_valid=1; rsp_p and rsp_id stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid<=0, state<=IDLE.
  - Backpressure of any length holds RESP indefinitely; mul_a and mul_b stay unchanged.
- No accept occurs in the same cycle as a response handshake. Back-to-back throughput is one op per MUL_LAT+2 cycles when rsp_ready is held at 1.
- A requester that drops req_valid before being granted is simply skipped; no state is kept for it.
- Requesters must hold req_a, req_b and req_valid stable until their req_ready is seen. The controller registers operands on accept and never re-reads them.
- ptr advances only on accept, giving round-robin fairness. A requester asserting req_valid continuously is served within NREQ grants.
- rst asserted mid-operation (WAIT or RESP): everything returns to reset values immediately. An in-flight response is dropped and no rsp_valid is emitted.
- The product is passed through unmodified: 8 bits, max 15*15=225, no overflow possible.
- cnt width: ceil(log2(MUL_LAT+1)) bits; never wraps, since it is reset on accept.

Test Plan:
- Single op: rst pulse, then req_valid[0]=1 with a=3, b=5 (ideal multiplier model) -> req_ready[0] high the same cycle; rsp_valid rises 8 cycles after accept with rsp_p=15, rsp_id=0; busy high from accept through the handshake.
- Round-robin: all four valid with (a,b)=(1,2),(3,4),(5,6),(15,15), rsp_ready=1 -> grant order 0,1,2,3; responses 2,12,30,225; accept edges spaced 10 cycles apart.
- Fairness: req 2 and req 3 held valid continuously after ptr=3 -> grants alternate 3,2,3,2; neither is starved.
- Backpressure: rsp_ready=0 for 20 cycles during RESP with req 1 valid -> rsp_p and rsp_id stable and mul_a/mul_b unchanged; req_ready stays 0 until 1 cycle after rsp_ready=1.
- Mid-op reset: rst asserted at cnt=4 in WAIT -> outputs zero asynchronously; after release, pending req 0 (a=7, b=9) is re-accepted and returns 63.
- Operand hold: change req_a[0] after accept -> mul_a unchanged through WAIT; the product reflects the accepted value.
